// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the downstream load/store port.
// The arbiter takes the slave modport; the master modport is the environment's view.
interface mem_arbiter_if;
    logic        m0_req,   m1_req;
    logic [31:0] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_wr,    m1_wr;
    logic [2:0]  m0_size,  m1_size;
    logic        m0_gnt,   m1_gnt;
    logic        m0_done,  m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m_err;
    logic        s_en;
    logic [31:0] s_addr,   s_wdata;
    logic        s_wr;
    logic [2:0]  s_size;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic        busy;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wr, m1_wr, m0_size, m1_size, s_rdata, s_ready,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m_err,
               s_en, s_addr, s_wdata, s_wr, s_size, busy
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wr, m1_wr, m0_size, m1_size, s_rdata, s_ready,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m_err,
               s_en, s_addr, s_wdata, s_wr, s_size, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer (IDLE/ISSUE/WAIT/DONE) in front of one load/store memory port.
// Optional WAIT-state timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int M1_MAX_WAIT    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          CLK,
    input  logic          BTN_N,
    mem_arbiter_if.slave  bus
);
    localparam int              AGE_W   = $clog2(M1_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(M1_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q;
    logic             owner_q;
    logic [AGE_W-1:0] age_q, age_d;
    logic             s_en_q, s_wr_q;
    logic [31:0]      s_addr_q, s_wdata_q;
    logic [2:0]       s_size_q;
    logic             m0_gnt_q, m1_gnt_q, m0_done_q, m1_done_q, m_err_q;
    logic [31:0]      m0_rdata_q, m1_rdata_q;
    logic             any_req, pick_m1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    assign any_req = bus.m0_req | bus.m1_req;
    // Master 0 has priority unless master 1 has waited long enough.
    assign pick_m1 = bus.m1_req & (~bus.m0_req | (age_q >= AGE_MAX));

    always_comb begin
        age_d = age_q;
        if (state_q == IDLE && any_req && pick_m1)
            age_d = '0;
        else if (bus.m1_req && !m1_gnt_q && age_q != AGE_MAX)
            age_d = age_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            age_q      <= '0;
            s_en_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_size_q   <= '0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m_err_q    <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            age_q     <= age_d;
            s_en_q    <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            m_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= pick_m1;
                        s_addr_q  <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
                        s_wdata_q <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                        s_wr_q    <= pick_m1 ? bus.m1_wr    : bus.m0_wr;
                        s_size_q  <= pick_m1 ? bus.m1_size  : bus.m0_size;
                        s_en_q    <= 1'b1;
                        m0_gnt_q  <= ~pick_m1;
                        m1_gnt_q  <= pick_m1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A ready on the final allowed WAIT cycle still completes normally.
                    if (bus.s_ready) begin
                        if (owner_q) m1_rdata_q <= bus.s_rdata;
                        else         m0_rdata_q <= bus.s_rdata;
                        m0_done_q <= ~owner_q;
                        m1_done_q <= owner_q;
                        state_q   <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        if (owner_q) m1_rdata_q <= 32'hDEADBEEF;
                        else         m0_rdata_q <= 32'hDEADBEEF;
                        m0_done_q <= ~owner_q;
                        m1_done_q <= owner_q;
                        m_err_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    m0_gnt_q <= 1'b0;
                    m1_gnt_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m0_gnt   = m0_gnt_q;
    assign bus.m1_gnt   = m1_gnt_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m_err    = m_err_q;
    assign bus.s_en     = s_en_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.s_wr     = s_wr_q;
    assign bus.s_size   = s_size_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
